// File: rtl/lsq_fifo_if.sv
`default_nettype none
// ============================================================================
// Module  : lsq_fifo_if (with lsq_fifo_pkg)
// Brief   : AGU, data-memory and CDB signal bundle of the load/store queue.
// Revision: 1.0 - initial release
// ============================================================================

package lsq_fifo_pkg;
    typedef enum logic [2:0] {
        MEM_LB  = 3'd0,
        MEM_LH  = 3'd1,
        MEM_LW  = 3'd2,
        MEM_LBU = 3'd3,
        MEM_LHU = 3'd4,
        MEM_SB  = 3'd5,
        MEM_SH  = 3'd6,
        MEM_SW  = 3'd7
    } mem_op_e;
endpackage

interface lsq_fifo_if #(
    parameter int ROB_IDX_W = 5
);
    import lsq_fifo_pkg::*;

    logic                 agu_valid;
    logic                 agu_ready;
    logic [ROB_IDX_W-1:0] agu_rob_id;
    mem_op_e              agu_fu_opcode;
    logic [31:0]          agu_addr;
    logic [3:0]           agu_mask;
    logic [31:0]          agu_wdata;
    logic [ROB_IDX_W-1:0] rob_head_id;

    logic [31:0]          dmem_addr;
    logic [3:0]           dmem_rmask;
    logic [3:0]           dmem_wmask;
    logic [31:0]          dmem_wdata;
    logic [31:0]          dmem_rdata;
    logic                 dmem_resp;

    logic                 cdb_valid;
    logic [ROB_IDX_W-1:0] cdb_rob_id;
    logic [31:0]          cdb_rd_value;

    modport slave (
        input  agu_valid, agu_rob_id, agu_fu_opcode, agu_addr, agu_mask, agu_wdata,
        input  rob_head_id, dmem_rdata, dmem_resp,
        output agu_ready, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        output cdb_valid, cdb_rob_id, cdb_rd_value
    );

    modport master (
        output agu_valid, agu_rob_id, agu_fu_opcode, agu_addr, agu_mask, agu_wdata,
        output rob_head_id, dmem_rdata, dmem_resp,
        input  agu_ready, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        input  cdb_valid, cdb_rob_id, cdb_rd_value
    );
endinterface

`default_nettype wire

// File: rtl/lsq_fifo.sv
`default_nettype none
// ============================================================================
// Module  : lsq_fifo
// Brief   : In-order load/store queue: one memory request at a time, CDB result.
// Revision: 1.0 - initial release
// ============================================================================

module lsq_fifo
    import lsq_fifo_pkg::*;
#(
    parameter int LSQ_DEPTH = 8,
    parameter int ROB_IDX_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    lsq_fifo_if.slave   bus
);

    localparam int                PTR_W      = $clog2(LSQ_DEPTH);
    localparam logic [PTR_W:0]    C_FULL     = (PTR_W + 1)'(LSQ_DEPTH);
    localparam logic [PTR_W:0]    C_CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0]  C_PTR_ONE  = PTR_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

    logic [ROB_IDX_W-1:0] r_rob   [LSQ_DEPTH];
    mem_op_e              r_op    [LSQ_DEPTH];
    logic [31:0]          r_addr  [LSQ_DEPTH];
    logic [3:0]           r_mask  [LSQ_DEPTH];
    logic [31:0]          r_wdata [LSQ_DEPTH];

    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_tail;
    logic [PTR_W:0]       r_count;
    state_e               r_state;
    state_e               w_state_next;

    logic [31:0]          r_dmem_addr;
    logic [3:0]           r_dmem_rmask;
    logic [3:0]           r_dmem_wmask;
    logic [31:0]          r_dmem_wdata;
    logic                 r_cdb_valid;
    logic [ROB_IDX_W-1:0] r_cdb_rob_id;
    logic [31:0]          r_cdb_rd_value;

    logic                 w_enq;
    logic                 w_deq;
    logic                 w_issue;
    logic                 w_head_is_load;
    logic                 w_eligible;
    logic [1:0]           w_lane;
    logic [31:0]          w_shifted;
    logic [31:0]          w_load_val;
    logic [31:0]          w_store_data;

    // Byte lane of the lowest enabled byte; masks arrive pre-shifted to the offset.
    function automatic logic [1:0] low_lane(input logic [3:0] mask);
        if (mask[0])      return 2'd0;
        else if (mask[1]) return 2'd1;
        else if (mask[2]) return 2'd2;
        else              return 2'd3;
    endfunction

    assign bus.agu_ready = (r_count != C_FULL);
    assign w_enq         = bus.agu_valid && bus.agu_ready;
    assign w_deq         = (r_state == ST_MEM_WAIT) && bus.dmem_resp;

    assign w_head_is_load = r_op[r_head] inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
    assign w_eligible     = (r_count != '0) &&
                            (w_head_is_load || (r_rob[r_head] == bus.rob_head_id));
    assign w_lane         = low_lane(r_mask[r_head]);
    assign w_shifted      = bus.dmem_rdata >> {w_lane, 3'b000};
    assign w_store_data   = r_wdata[r_head] << {w_lane, 3'b000};

    always_comb begin
        w_load_val = '0;
        case (r_op[r_head])
            MEM_LB:  w_load_val = {{24{w_shifted[7]}}, w_shifted[7:0]};
            MEM_LBU: w_load_val = {24'd0, w_shifted[7:0]};
            MEM_LH:  w_load_val = {{16{w_shifted[15]}}, w_shifted[15:0]};
            MEM_LHU: w_load_val = {16'd0, w_shifted[15:0]};
            MEM_LW:  w_load_val = w_shifted;
            default: w_load_val = '0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_eligible) begin
                    w_state_next = ST_MEM_WAIT;
                    w_issue      = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (bus.dmem_resp) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_rob[r_tail]   <= bus.agu_rob_id;
            r_op[r_tail]    <= bus.agu_fu_opcode;
            r_addr[r_tail]  <= bus.agu_addr;
            r_mask[r_tail]  <= bus.agu_mask;
            r_wdata[r_tail] <= bus.agu_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_enq) r_tail <= r_tail + C_PTR_ONE;
            if (w_deq) r_head <= r_head + C_PTR_ONE;
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Request masks are single-cycle pulses; address and write data persist until the response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dmem_addr    <= '0;
            r_dmem_rmask   <= '0;
            r_dmem_wmask   <= '0;
            r_dmem_wdata   <= '0;
            r_cdb_valid    <= 1'b0;
            r_cdb_rob_id   <= '0;
            r_cdb_rd_value <= '0;
        end else begin
            r_dmem_rmask <= '0;
            r_dmem_wmask <= '0;
            if (w_issue) begin
                r_dmem_addr <= r_addr[r_head];
                if (w_head_is_load) begin
                    r_dmem_rmask <= r_mask[r_head];
                end else begin
                    r_dmem_wmask <= r_mask[r_head];
                    r_dmem_wdata <= w_store_data;
                end
            end
            r_cdb_valid <= w_deq;
            if (w_deq) begin
                r_cdb_rob_id   <= r_rob[r_head];
                r_cdb_rd_value <= w_load_val;
            end
        end
    end

    assign bus.dmem_addr    = r_dmem_addr;
    assign bus.dmem_rmask   = r_dmem_rmask;
    assign bus.dmem_wmask   = r_dmem_wmask;
    assign bus.dmem_wdata   = r_dmem_wdata;
    assign bus.cdb_valid    = r_cdb_valid;
    assign bus.cdb_rob_id   = r_cdb_rob_id;
    assign bus.cdb_rd_value = r_cdb_rd_value;

endmodule

`default_nettype wire

// File: tb/tb_lsq_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_lsq_fifo
// Brief   : Scoreboard bench for lsq_fifo with a scripted data-memory responder.
// Revision: 1.0 - initial release
// ============================================================================

module tb_lsq_fifo;
    import lsq_fifo_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } req_t;

    typedef struct {
        logic [4:0]  rob;
        logic [31:0] val;
    } cdb_t;

    logic clk;
    logic rst;

    lsq_fifo_if #(.ROB_IDX_W(5)) bus ();

    lsq_fifo #(.LSQ_DEPTH(8), .ROB_IDX_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_tests  = 0;
    int          n_failed = 0;
    req_t        exp_req[$];
    cdb_t        exp_cdb[$];
    int          req_cnt  = 0;
    int          resp_cnt = 0;
    int          cdb_cnt  = 0;
    logic [31:0] pend_addr;
    logic [31:0] pend_rdata;
    logic        prev_req = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (prev_req) check_val("mask_pulse", {28'd0, bus.dmem_rmask | bus.dmem_wmask}, 32'd0);
            prev_req <= 1'b0;
            if ((bus.dmem_rmask | bus.dmem_wmask) != 4'd0) begin
                prev_req <= 1'b1;
                if (exp_req.size() == 0) begin
                    check_val("req_unexpected", 32'd1, 32'd0);
                end else begin
                    req_t r;
                    r = exp_req.pop_front();
                    check_val("req_addr", bus.dmem_addr, r.addr);
                    check_val("req_rmask", {28'd0, bus.dmem_rmask}, {28'd0, r.rmask});
                    check_val("req_wmask", {28'd0, bus.dmem_wmask}, {28'd0, r.wmask});
                    if (r.wmask != 4'd0) check_val("req_wdata", bus.dmem_wdata, r.wdata);
                    pend_addr  = r.addr;
                    pend_rdata = r.rdata;
                end
                req_cnt++;
            end
            if (bus.cdb_valid) begin
                cdb_cnt++;
                if (exp_cdb.size() == 0) begin
                    check_val("cdb_unexpected", 32'd1, 32'd0);
                end else begin
                    cdb_t c;
                    c = exp_cdb.pop_front();
                    check_val("cdb_rob_id", {27'd0, bus.cdb_rob_id}, {27'd0, c.rob});
                    check_val("cdb_value", bus.cdb_rd_value, c.val);
                end
            end
        end
    end

    task automatic enq(input mem_op_e op, input int rob, input logic [31:0] addr,
                       input logic [3:0] mask, input logic [31:0] wdata,
                       input logic [31:0] exp_wdata, input logic [31:0] rdata,
                       input logic [31:0] exp_val);
        int   n = 0;
        logic st;
        req_t r;
        cdb_t c;
        st = op inside {MEM_SB, MEM_SH, MEM_SW};
        r.addr  = addr;
        r.rmask = st ? 4'd0 : mask;
        r.wmask = st ? mask : 4'd0;
        r.wdata = exp_wdata;
        r.rdata = rdata;
        c.rob   = 5'(rob);
        c.val   = st ? 32'd0 : exp_val;
        exp_req.push_back(r);
        exp_cdb.push_back(c);
        bus.agu_fu_opcode = op;
        bus.agu_rob_id    = 5'(rob);
        bus.agu_addr      = addr;
        bus.agu_mask      = mask;
        bus.agu_wdata     = wdata;
        bus.agu_valid     = 1'b1;
        while (!bus.agu_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check_val("enq_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.agu_valid = 1'b0;
    endtask

    task automatic respond();
        int n = 0;
        while (req_cnt <= resp_cnt && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            check_val("req_timeout", 32'd0, 32'd1);
        end else begin
            @(negedge clk);
            check_val("addr_hold", bus.dmem_addr, pend_addr);
            bus.dmem_rdata = pend_rdata;
            bus.dmem_resp  = 1'b1;
            @(negedge clk);
            bus.dmem_resp  = 1'b0;
        end
        resp_cnt = req_cnt;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_cdb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("drain", 32'(exp_cdb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        rst = 1'b0;
        bus.agu_valid     = 1'b0;
        bus.agu_rob_id    = '0;
        bus.agu_fu_opcode = MEM_LB;
        bus.agu_addr      = '0;
        bus.agu_mask      = '0;
        bus.agu_wdata     = '0;
        bus.rob_head_id   = '0;
        bus.dmem_rdata    = '0;
        bus.dmem_resp     = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_ready", {31'd0, bus.agu_ready}, 32'd1);
        check_val("rst_cdb_valid", {31'd0, bus.cdb_valid}, 32'd0);
        check_val("rst_rmask", {28'd0, bus.dmem_rmask}, 32'd0);
        check_val("rst_wmask", {28'd0, bus.dmem_wmask}, 32'd0);
        check_val("rst_addr", bus.dmem_addr, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Load formatting
        enq(MEM_LB,  1, 32'h100, 4'b0100, 32'h0, 32'h0, 32'h12803456, 32'hFFFFFF80);
        respond();
        enq(MEM_LHU, 2, 32'h104, 4'b1100, 32'h0, 32'h0, 32'hBEEF0000, 32'h0000BEEF);
        enq(MEM_LW,  4, 32'h108, 4'b1111, 32'h0, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D);
        enq(MEM_LH,  5, 32'h10C, 4'b0011, 32'h0, 32'h0, 32'h00008001, 32'hFFFF8001);
        enq(MEM_LBU, 6, 32'h110, 4'b1000, 32'h0, 32'h0, 32'hF0000000, 32'h000000F0);
        repeat (4) respond();
        drain();

        // Store waits for ROB head
        bus.rob_head_id = 5'd2;
        base = req_cnt;
        enq(MEM_SB, 3, 32'h300, 4'b0010, 32'h000000AB, 32'h0000AB00, 32'h0, 32'h0);
        repeat (5) @(negedge clk);
        check_val("sb_blocked", 32'(req_cnt - base), 32'd0);
        bus.rob_head_id = 5'd3;
        respond();
        check_val("sb_wdata", bus.dmem_wdata, 32'h0000AB00);
        drain();
        bus.rob_head_id = 5'd11;
        enq(MEM_SH, 11, 32'h304, 4'b1100, 32'h00001234, 32'h12340000, 32'h0, 32'h0);
        respond();
        drain();

        // Fill to full, hold off a ninth entry, wrap the pointers
        for (int i = 0; i < 8; i++)
            enq(MEM_LW, 12 + i, 32'h200 + 32'(4 * i), 4'b1111, 32'h0, 32'h0,
                32'hA0000000 + 32'(i), 32'hA0000000 + 32'(i));
        @(negedge clk);
        check_val("full_ready", {31'd0, bus.agu_ready}, 32'd0);
        fork
            enq(MEM_LW, 20, 32'h220, 4'b1111, 32'h0, 32'h0, 32'hA0000008, 32'hA0000008);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check_val("full_hold", {31'd0, bus.agu_ready}, 32'd0);
                end
                respond();
            end
        join
        repeat (8) respond();
        drain();

        // Load behind an unretired store
        bus.rob_head_id = 5'd0;
        base = req_cnt;
        enq(MEM_SW, 7, 32'h400, 4'b1111, 32'h11223344, 32'h11223344, 32'h0, 32'h0);
        enq(MEM_LW, 8, 32'h404, 4'b1111, 32'h0, 32'h0, 32'h55667788, 32'h55667788);
        repeat (5) @(negedge clk);
        check_val("ld_behind_st", 32'(req_cnt - base), 32'd0);
        bus.rob_head_id = 5'd7;
        respond();
        respond();
        drain();

        // Reset during MEM_WAIT
        enq(MEM_LW, 21, 32'h500, 4'b1111, 32'h0, 32'h0, 32'h1, 32'h1);
        enq(MEM_LW, 22, 32'h504, 4'b1111, 32'h0, 32'h0, 32'h2, 32'h2);
        enq(MEM_LW, 23, 32'h508, 4'b1111, 32'h0, 32'h0, 32'h3, 32'h3);
        repeat (3) @(negedge clk);
        check_val("pre_rst_issued", {31'd0, req_cnt > resp_cnt}, 32'd1);
        #2 rst = 1'b0;
        #1;
        exp_req.delete();
        exp_cdb.delete();
        resp_cnt = req_cnt;
        check_val("mrst_ready", {31'd0, bus.agu_ready}, 32'd1);
        check_val("mrst_addr", bus.dmem_addr, 32'd0);
        check_val("mrst_wdata", bus.dmem_wdata, 32'd0);
        check_val("mrst_masks", {24'd0, bus.dmem_rmask, bus.dmem_wmask}, 32'd0);
        check_val("mrst_cdb", {31'd0, bus.cdb_valid}, 32'd0);
        check_val("mrst_cdb_val", bus.cdb_rd_value, 32'd0);
        check_val("mrst_cdb_rob", {27'd0, bus.cdb_rob_id}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        base = cdb_cnt;
        @(negedge clk);
        bus.dmem_resp = 1'b1;
        @(negedge clk);
        bus.dmem_resp = 1'b0;
        repeat (3) @(negedge clk);
        check_val("stray_resp_cdb", 32'(cdb_cnt - base), 32'd0);
        check_val("stray_resp_req", 32'(req_cnt - resp_cnt), 32'd0);

        enq(MEM_LW, 9, 32'h600, 4'b1111, 32'h0, 32'h0, 32'h0BADF00D, 32'h0BADF00D);
        respond();
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lsq_fifo.md
Name: lsq_fifo

Overview:
- In-order load/store queue sitting downstream of the memory-stage AGU.
- Accepts address-generated memory uops (rob_id, word-aligned address, byte mask, store data, opcode) and holds them in a circular FIFO.
- Issues them one at a time to the data memory port.
- Formats load data and broadcasts load/store completion on the CDB to the ROB.

Parameters:
- LSQ_DEPTH, 8, number of queue entries; power of two, ≥2.
- ROB_IDX_W, 5, width of ROB index.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- agu_valid  in  1  AGU output entry valid.
- agu_ready  out  1  LSQ can accept an entry this cycle.
- agu_rob_id  in  ROB_IDX_W  ROB index of the uop.
- agu_fu_opcode  in  uop_types mem opcode  MEM_LB/LH/LW/LBU/LHU/SB/SH/SW.
- agu_addr  in  32  word-aligned address, bits [1:0] = 0.
- agu_mask  in  4  byte-enable mask, already shifted to the byte offset.
- agu_wdata  in  32  rs2 value, unshifted.
- rob_head_id  in  ROB_IDX_W  ROB index currently at commit head.
- dmem_addr  out  32  memory address.
- dmem_rmask  out  4  read byte enables; nonzero = read request.
- dmem_wmask  out  4  write byte enables; nonzero = write request.
- dmem_wdata  out  32  write data, byte-lane aligned.
- dmem_rdata  in  32  read data, valid with dmem_resp.
- dmem_resp  in  1  memory response, one-cycle pulse.
- cdb_valid  out  1  completion broadcast valid.
- cdb_rob_id  out  ROB_IDX_W  completing uop ROB index.
- cdb_rd_value  out  32  load result; 0 for stores.

Behaviour:
Storage
- Circular buffer of LSQ_DEPTH entries.
- head/tail pointers of log2(LSQ_DEPTH) bits, wrapping modulo depth.
- Count register of log2(LSQ_DEPTH)+1 bits.

Enqueue and dequeue
- agu_ready = (count != LSQ_DEPTH); purely combinational from count, no bypass.
- Enqueue: when agu_valid && agu_ready, write the entry at tail, then tail++.
- Dequeue: head++ on the dmem_resp cycle.
- Simultaneous enqueue and dequeue leaves count unchanged.
- When full, an enqueue is refused even if a dequeue happens in the same cycle.

FSM: IDLE, MEM_WAIT
- IDLE → MEM_WAIT when count != 0 and the head entry is eligible.
  - A load is always eligible.
  - A store is eligible only when head.rob_id == rob_head_id.
- On that transition edge, register the request outputs:
  - dmem_addr = head.addr.
  - Load: dmem_rmask = head.mask, dmem_wmask = 0.
  - Store: dmem_wmask = head.mask, dmem_rmask = 0; dmem_wdata = head.wdata << (8 × index of lowest set mask bit).
- Masks are asserted for exactly one cycle, then return to 0.
- dmem_addr and dmem_wdata are held stable until dmem_resp.
- MEM_WAIT → IDLE on dmem_resp. No new request may issue in the cycle dmem_resp is seen; the next issue is at the earliest one cycle later.
- An entry enqueued into an empty queue issues at the earliest on the cycle after enqueue.

Load formatting
- off = index of the lowest set mask bit; shifted = dmem_rdata >> (8 × off).
- LB: sign-extend [7:0]. LBU: zero-extend [7:0].
- LH: sign-extend [15:0]. LHU: zero-extend [15:0].
- LW: full word.

CDB
- cdb_valid is registered: asserted for exactly one cycle, on the cycle after dmem_resp.
- cdb_rob_id = entry rob_id; cdb_rd_value = formatted load data, or 0 for a store.
- The CDB always accepts; there is no back-pressure.

Reset (async, rst low)
- Pointers, count and FSM cleared; FSM → IDLE.
- cdb_valid = 0, dmem_rmask = 0, dmem_wmask = 0.
- dmem_addr, dmem_wdata, cdb_rob_id and cdb_rd_value reset to 0.
- Reset during MEM_WAIT abandons the request; a later stray dmem_resp while IDLE is ignored.

Other rules
- dmem_resp while in IDLE is ignored.
- Ordering is strictly FIFO: a load behind an unretired store waits for it. No forwarding, no flush.

Test Plan:
1. LB, addr 0x100, mask 0100, rdata 0x12_80_34_56 → dmem_rmask = 0100 for one cycle; cdb_valid one cycle after resp with value 0xFFFFFF80 and the matching rob_id.
2. LHU, mask 1100, rdata 0xBEEF_0000 → cdb_rd_value = 0x0000BEEF. LW, mask 1111 → raw word passed unchanged.
3. SB rob_id 3, mask 0010, wdata 0xAB; rob_head_id = 2 → no dmem request. Set rob_head_id = 3 → dmem_wmask = 0010, dmem_wdata = 0x0000AB00; after resp, cdb_valid with rob_id 3 and value 0.
4. Enqueue 8 entries with memory stalled → agu_ready drops after the 8th. A 9th agu_valid is held off until the first dmem_resp; order is preserved across pointer wrap.
5. Load queued behind a blocked store → load not issued until the store completes; CDB broadcasts appear in enqueue order.
6. rst low while in MEM_WAIT with 3 entries → queue empties, all outputs 0; a stray dmem_resp after reset produces no cdb_valid.
